// File: rtl/uart8_pkg.sv
// Shared types and divider derivations for the uart8 8N1 UART.
package uart8_pkg;

    localparam int unsigned SAMPLE_MID      = 8;
    localparam int unsigned SAMPLES_PER_BIT = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_BIT,
        RX_DATA_BITS,
        RX_STOP_BIT,
        RX_WAIT_IDLE
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Rounded clocks per rx oversample tick.
    function automatic int unsigned calc_rx_div(input int unsigned clock_rate,
                                                input int unsigned baud_rate);
        return (clock_rate + (baud_rate * SAMPLES_PER_BIT) / 2) / (baud_rate * SAMPLES_PER_BIT);
    endfunction

    // Rounded clocks per transmitted bit.
    function automatic int unsigned calc_tx_div(input int unsigned clock_rate,
                                                input int unsigned baud_rate);
        return (clock_rate + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart8_baud_gen.sv
// Free-running divider producing a one-clk tick every DIV clocks; restart realigns it.
module uart8_baud_gen #(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        tick    = (count_q == LAST);
        count_d = count_q + 1'b1;
        if (restart || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart8.sv
// 8N1 UART: 16x oversampling receiver and 1x baud transmitter, fully independent.
module uart8
    import uart8_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxEn,
    input  logic       rx,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] out,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] in,
    output logic       txBusy,
    output logic       txDone,
    output logic       tx
);

    localparam int unsigned RX_DIV = calc_rx_div(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned TX_DIV = calc_tx_div(CLOCK_RATE, BAUD_RATE);
    localparam logic [3:0]  MID    = 4'(SAMPLE_MID);
    localparam logic [3:0]  LAST   = 4'(SAMPLES_PER_BIT - 1);

    logic rx_tick, tx_tick, tx_restart;

    uart8_baud_gen #(.DIV(RX_DIV)) u_rx_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (1'b0),
        .tick    (rx_tick)
    );

    uart8_baud_gen #(.DIV(TX_DIV)) u_tx_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (tx_restart),
        .tick    (tx_tick)
    );

    // Receiver
    logic       rx_meta_q, rx_sync_q;
    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] sample_q, sample_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] out_q, out_d;
    logic       rx_busy_q, rx_busy_d;
    logic       rx_done_q, rx_done_d;
    logic       rx_err_q, rx_err_d;

    always_comb begin
        rx_state_d = rx_state_q;
        sample_d   = sample_q;
        rx_bit_d   = rx_bit_q;
        shift_d    = shift_q;
        out_d      = out_q;
        rx_busy_d  = rx_busy_q;
        rx_done_d  = 1'b0;
        rx_err_d   = rx_err_q;
        if (!rxEn) begin
            rx_state_d = RX_IDLE;
            rx_busy_d  = 1'b0;
        end else if (rx_tick) begin
            sample_d = sample_q + 4'd1;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_err_d   = 1'b0;
                        sample_d   = '0;
                        rx_busy_d  = 1'b1;
                        rx_state_d = RX_START_BIT;
                    end
                end
                RX_START_BIT: begin
                    if (sample_q == MID) begin
                        if (!rx_sync_q) begin
                            sample_d   = '0;
                            rx_bit_d   = '0;
                            rx_state_d = RX_DATA_BITS;
                        end else begin
                            rx_busy_d  = 1'b0;
                            rx_state_d = RX_IDLE;
                        end
                    end
                end
                RX_DATA_BITS: begin
                    if (sample_q == MID) begin
                        shift_d = {rx_sync_q, shift_q[7:1]};
                    end
                    if (sample_q == LAST) begin
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RX_STOP_BIT;
                        end
                    end
                end
                RX_STOP_BIT: begin
                    if (sample_q == MID) begin
                        rx_busy_d = 1'b0;
                        if (rx_sync_q) begin
                            out_d      = shift_q;
                            rx_done_d  = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_err_d   = 1'b1;
                            rx_state_d = RX_WAIT_IDLE;
                        end
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            sample_q   <= '0;
            rx_bit_q   <= '0;
            shift_q    <= '0;
            out_q      <= '0;
            rx_busy_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            sample_q   <= sample_d;
            rx_bit_q   <= rx_bit_d;
            shift_q    <= shift_d;
            out_q      <= out_d;
            rx_busy_q  <= rx_busy_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rxBusy = rx_busy_q;
    assign rxDone = rx_done_q;
    assign rxErr  = rx_err_q;
    assign out    = out_q;

    // Transmitter
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic       tx_q, tx_d;
    logic       tx_busy_q, tx_busy_d;
    logic       tx_done_q, tx_done_d;

    // Starting a frame realigns the bit divider so the start bit is a full period.
    assign tx_restart = (tx_state_q == TX_IDLE) && txEn && txStart;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_restart) begin
                    tx_data_d  = in;
                    tx_busy_d  = 1'b1;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_d       = tx_data_q[0];
                    tx_data_d  = tx_data_q >> 1;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_d      = tx_data_q[0];
                        tx_data_d = tx_data_q >> 1;
                        tx_bit_d  = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_busy_d  = 1'b0;
                    tx_done_d  = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign txBusy = tx_busy_q;
    assign txDone = tx_done_q;
    assign tx     = tx_q;

endmodule

// File: tb/tb_uart8.sv
// Randomized self-checking bench for uart8, run at a scaled clock/baud for short frames.
module tb_uart8;

    localparam int unsigned CLK_HZ   = 1_600_000;
    localparam int unsigned BAUD     = 10_000;
    localparam int          TXD      = 160;  // round(1.6e6 / 1e4)
    localparam int          BIT_CLKS = 160;  // 16 ticks of round(1.6e6 / 160e3) = 10

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxEn = 1'b0, txEn = 1'b0, txStart = 1'b0;
    logic       rx_drv = 1'b1, loop = 1'b0;
    logic [7:0] din = '0;
    logic       rx_line;
    logic       rxBusy, rxDone, rxErr, txBusy, txDone, tx;
    logic [7:0] dout;

    assign rx_line = loop ? tx : rx_drv;

    uart8 #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxEn    (rxEn),
        .rx      (rx_line),
        .rxBusy  (rxBusy),
        .rxDone  (rxDone),
        .rxErr   (rxErr),
        .out     (dout),
        .txEn    (txEn),
        .txStart (txStart),
        .in      (din),
        .txBusy  (txBusy),
        .txDone  (txDone),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard of received bytes and tx completion pulses.
    logic [7:0] rx_got[$];
    int         tx_done_cnt = 0;

    always @(negedge clk) begin
        if (rxDone) rx_got.push_back(dout);
        if (txDone) tx_done_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame on rx; stop bit held low for stop_low clocks first.
    task automatic rx_frame(input logic [7:0] b, input int stop_low);
        rx_drv = 1'b0;
        clks(BIT_CLKS);
        check("rx_busy_in_frame", rxBusy, 1);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            clks(BIT_CLKS);
        end
        rx_drv = 1'b0;
        clks(stop_low);
        rx_drv = 1'b1;
        clks(BIT_CLKS - stop_low);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        check({tag, "_pulses"}, rx_got.size(), 1);
        got = (rx_got.size() > 0) ? rx_got.pop_front() : 8'hxx;
        check(tag, got, exp);
        rx_got.delete();
    endtask

    // Send a byte and check every bit at its first and last clock.
    task automatic tx_send(input logic [7:0] b);
        logic [9:0] frame;
        int         done0;
        frame = {1'b1, b, 1'b0};
        done0 = tx_done_cnt;
        din = b;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("tx_bit_first", tx, frame[k]);
            check("tx_busy", txBusy, 1);
            clks(TXD - 1);
            check("tx_bit_last", tx, frame[k]);
            clks(1);
        end
        check("tx_done_pulse", txDone, 1);
        check("tx_busy_after", txBusy, 0);
        clks(1);
        check("tx_done_once", tx_done_cnt - done0, 1);
    endtask

    task automatic wait_tx_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 * TXD && !ok; i++) begin
            @(negedge clk);
            if (txDone) ok = 1'b1;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit         ok;
        logic [7:0] b;
        logic [7:0] exp_q[$];

        clks(4);
        check("rst_tx", tx, 1);
        check("rst_rx_busy", rxBusy, 0);
        check("rst_rx_done", rxDone, 0);
        check("rst_rx_err", rxErr, 0);
        check("rst_tx_busy", txBusy, 0);
        check("rst_tx_done", txDone, 0);
        check("rst_out", dout, 8'h00);
        rst_n = 1'b1;
        rxEn = 1'b1;
        txEn = 1'b1;
        clks(20);

        // Plain reception
        rx_frame(8'h55, 0);
        expect_rx("rx_55", 8'h55);
        check("rx_55_err", rxErr, 0);
        check("rx_55_busy", rxBusy, 0);

        // Stop bit low across its mid sample
        rx_frame(8'h3C, 107);
        clks(40);
        check("ferr_no_done", rx_got.size(), 0);
        check("ferr_flag", rxErr, 1);
        check("ferr_out_kept", dout, 8'h55);
        check("ferr_busy", rxBusy, 0);
        clks(200);
        check("ferr_flag_held", rxErr, 1);

        // Short low pulse: false start
        rx_drv = 1'b0;
        clks(25);
        check("fs_busy_high", rxBusy, 1);
        clks(6);
        rx_drv = 1'b1;
        clks(300);
        check("fs_busy_low", rxBusy, 0);
        check("fs_no_done", rx_got.size(), 0);
        check("fs_no_err", rxErr, 0);

        // Transmit A3
        tx_send(8'hA3);

        // Loopback 00 then FF, second frame started by a held txStart
        loop = 1'b1;
        clks(10);
        din = 8'h00;
        txStart = 1'b1;
        wait_tx_done(ok);
        check("lb_done0", ok, 1);
        din = 8'hFF;
        clks(1);
        check("lb_retrig_tx", tx, 0);
        check("lb_retrig_busy", txBusy, 1);
        txStart = 1'b0;
        wait_tx_done(ok);
        check("lb_done1", ok, 1);
        clks(20);
        check("lb_count", rx_got.size(), 2);
        b = (rx_got.size() > 0) ? rx_got.pop_front() : 8'hxx;
        check("lb_byte0", b, 8'h00);
        b = (rx_got.size() > 0) ? rx_got.pop_front() : 8'hxx;
        check("lb_byte1", b, 8'hFF);
        rx_got.delete();

        // Random loopback frames
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            tx_send(b);
        end
        clks(20);
        check("rand_lb_count", rx_got.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            b = (rx_got.size() > 0) ? rx_got.pop_front() : 8'hxx;
            check("rand_lb_byte", b, exp_q.pop_front());
        end
        rx_got.delete();
        loop = 1'b0;
        clks(20);

        // Random direct rx frames
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            rx_frame(b, 0);
            clks($urandom_range(0, 30));
            expect_rx("rand_rx", b);
        end

        // rxEn dropped mid-frame
        rx_drv = 1'b0;
        clks(2 * BIT_CLKS);
        rxEn = 1'b0;
        clks(1);
        check("rxen_busy", rxBusy, 0);
        check("rxen_out_kept", dout, b);
        rx_drv = 1'b1;
        clks(20);
        rxEn = 1'b1;
        clks(400);
        check("rxen_no_done", rx_got.size(), 0);

        // Reset in the middle of rx and tx frames
        din = 8'h5A;
        txStart = 1'b1;
        clks(1);
        txStart = 1'b0;
        rx_drv = 1'b0;
        clks(4 * BIT_CLKS);
        rst_n = 1'b0;
        clks(1);
        rst_n = 1'b1;
        rx_drv = 1'b1;
        check("mrst_tx", tx, 1);
        check("mrst_tx_busy", txBusy, 0);
        check("mrst_tx_done", txDone, 0);
        check("mrst_rx_busy", rxBusy, 0);
        check("mrst_rx_done", rxDone, 0);
        check("mrst_rx_err", rxErr, 0);
        check("mrst_out", dout, 8'h00);
        clks(400);
        rx_got.delete();
        b = 8'($urandom);
        rx_frame(b, 0);
        expect_rx("mrst_rx_after", b);
        tx_send(8'h96);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
